// File: rtl/axis_frame_gen_if.sv
// -----------------------------------------------------------------------------
// axis_frame_gen_if
// Purpose : AXI4-Stream master/slave bundle used by the frame generator.
// Signals : tdata  - beat payload (DATA_WIDTH bits), master -> slave
//           tvalid - beat valid, master -> slave
//           tlast  - last beat of a frame, master -> slave
//           tready - sink ready, slave -> master
// -----------------------------------------------------------------------------
interface axis_frame_gen_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/axis_frame_gen.sv
// -----------------------------------------------------------------------------
// axis_frame_gen
// Purpose : Generates runs of AXI4-Stream frames carrying an incrementing data
//           pattern, with a programmable number of idle cycles between frames.
// Ports   : clk         - clock, all logic on rising edge
//           rst         - asynchronous active-low reset, released synchronously
//           start       - single-cycle run request (ignored while busy)
//           abort       - single-cycle request to stop at next frame boundary
//           frame_len   - beats per frame (sampled at accepted start)
//           frame_count - frames per run (sampled at accepted start)
//           gap_cycles  - idle cycles between frames (sampled at accepted start)
//           seed        - tdata of the first beat of a run
//           m_axis      - AXI4-Stream master (tdata/tvalid/tlast out, tready in)
//           busy        - high while a run is in progress
//           done        - one-cycle pulse when a run ends
//           frames_sent - frames completed in the current or last run
// -----------------------------------------------------------------------------
module axis_frame_gen #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int GAP_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [LEN_WIDTH-1:0]  frame_len,
    input  logic [LEN_WIDTH-1:0]  frame_count,
    input  logic [GAP_WIDTH-1:0]  gap_cycles,
    input  logic [DATA_WIDTH-1:0] seed,
    axis_frame_gen_if.master      m_axis,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_WIDTH-1:0]  frames_sent
);

    localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);
    localparam logic [GAP_WIDTH-1:0]  GAP_ONE  = GAP_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] DATA_ONE = DATA_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_e;

    // Reset synchronizer: assertion reaches the logic immediately, release is
    // delayed by two clock edges so every flop leaves reset in the same cycle.
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    state_e                state_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  count_q;
    logic [GAP_WIDTH-1:0]  gap_q;
    logic [GAP_WIDTH-1:0]  gap_cnt_q;
    logic [LEN_WIDTH-1:0]  beat_q;
    logic                  abort_pend_q;
    logic [DATA_WIDTH-1:0] tdata_q;
    logic                  tvalid_q;
    logic                  tlast_q;
    logic                  busy_q;
    logic                  done_q;
    logic [LEN_WIDTH-1:0]  frames_sent_q;

    logic                  xfer;
    logic [LEN_WIDTH-1:0]  beat_inc;
    logic [LEN_WIDTH-1:0]  frames_inc;
    logic                  last_frame;

    assign xfer       = tvalid_q & m_axis.tready;
    assign beat_inc   = beat_q + LEN_ONE;
    assign frames_inc = frames_sent_q + LEN_ONE;
    assign last_frame = (frames_inc == count_q);

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q       <= IDLE;
            len_q         <= '0;
            count_q       <= '0;
            gap_q         <= '0;
            gap_cnt_q     <= '0;
            beat_q        <= '0;
            abort_pend_q  <= 1'b0;
            tdata_q       <= '0;
            tvalid_q      <= 1'b0;
            tlast_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            frames_sent_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        frames_sent_q <= '0;
                        if ((frame_len != '0) && (frame_count != '0)) begin
                            len_q        <= frame_len;
                            count_q      <= frame_count;
                            gap_q        <= gap_cycles;
                            beat_q       <= '0;
                            abort_pend_q <= 1'b0;
                            tdata_q      <= seed;
                            tvalid_q     <= 1'b1;
                            tlast_q      <= (frame_len == LEN_ONE);
                            busy_q       <= 1'b1;
                            state_q      <= SEND;
                        end else begin
                            // Empty run: nothing to send, just report completion.
                            done_q <= 1'b1;
                        end
                    end
                end

                SEND: begin
                    if (abort) begin
                        abort_pend_q <= 1'b1;
                    end
                    if (xfer) begin
                        tdata_q <= tdata_q + DATA_ONE;
                        if (tlast_q) begin
                            frames_sent_q <= frames_inc;
                            beat_q        <= '0;
                            // An abort arriving on the closing beat still ends
                            // the run here, giving a single done pulse.
                            if (last_frame || abort_pend_q || abort) begin
                                state_q      <= IDLE;
                                tvalid_q     <= 1'b0;
                                tlast_q      <= 1'b0;
                                busy_q       <= 1'b0;
                                done_q       <= 1'b1;
                                abort_pend_q <= 1'b0;
                            end else if (gap_q == '0) begin
                                tlast_q <= (len_q == LEN_ONE);
                            end else begin
                                state_q   <= GAP;
                                tvalid_q  <= 1'b0;
                                tlast_q   <= 1'b0;
                                gap_cnt_q <= gap_q;
                            end
                        end else begin
                            beat_q  <= beat_inc;
                            tlast_q <= (beat_inc == (len_q - LEN_ONE));
                        end
                    end
                end

                GAP: begin
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (gap_cnt_q == GAP_ONE) begin
                        // Last idle cycle: next frame's first beat goes out next.
                        state_q  <= SEND;
                        tvalid_q <= 1'b1;
                        tlast_q  <= (len_q == LEN_ONE);
                    end else begin
                        gap_cnt_q <= gap_cnt_q - GAP_ONE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign m_axis.tdata  = tdata_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign frames_sent   = frames_sent_q;

endmodule
